// File: rtl/capture_pkg.sv
// ============================================================================
// Module : capture_pkg
// Brief  : Shared state encoding, trigger modes and sizing helper for the
//          capture/dump sequencer and its word serializer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package capture_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_FETCH     = 3'd3;
  localparam logic [2:0] ST_LATCH     = 3'd4;
  localparam logic [2:0] ST_SEND      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_TRIG = ST_WAIT_TRIG,
    S_CAPTURE   = ST_CAPTURE,
    S_FETCH     = ST_FETCH,
    S_LATCH     = ST_LATCH,
    S_SEND      = ST_SEND,
    S_DONE      = ST_DONE
  } state_e;

  localparam logic [1:0] TRIG_IMM    = 2'd0;
  localparam logic [1:0] TRIG_VSYNC  = 2'd1;
  localparam logic [1:0] TRIG_WINDOW = 2'd2;

  function automatic int bytes_per_word(input int data_width, input int pad_bytes);
    return data_width / 8 + pad_bytes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module : word_serializer
// Brief  : Shifts one loaded word out MSB-first as UART byte strobes, followed
//          by zero pad bytes; at most one strobe every other cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module word_serializer
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PAD_BYTES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_strobe,
  output logic                  last_byte
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, PAD_BYTES);
  localparam int CW  = $clog2(BPW + 1);
  localparam logic [CW-1:0] BPW_C = CW'(BPW);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            data_q, data_d;
  logic                  strobe_q, strobe_d;

  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    if (load) begin
      shreg_d = word;
      cnt_d   = BPW_C;
    end else if (tx_ready && !strobe_q && (cnt_q != '0)) begin
      // Zero fill makes the pad bytes fall out of the same shift path.
      strobe_d = 1'b1;
      data_d   = shreg_q[DATA_WIDTH-1 -: 8];
      shreg_d  = shreg_q << 8;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign tx_data   = data_q;
  assign tx_strobe = strobe_q;
  assign last_byte = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/capture_dump_sequencer.sv
// ============================================================================
// Module : capture_dump_sequencer
// Brief  : Arms, triggers and fills the debug capture RAM, then dumps it to
//          the UART. Define AUTO_REARM_EN for continuous capture/dump cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module capture_dump_sequencer
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int PAD_BYTES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [1:0]            trig_mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_window,
  input  logic                  vsync,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_strobe,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state
);

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  vsync_q;
  logic [ADDR_WIDTH-1:0] wcount_q, wcount_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  ser_load;
  logic                  ser_last;

  logic w_rise, w_trig, w_qual, w_cap_active, w_take;

  assign w_rise       = vsync && !vsync_q;
  // Reserved mode 3 falls through to immediate triggering.
  assign w_trig       = ((mode_q == TRIG_VSYNC) || (mode_q == TRIG_WINDOW)) ? w_rise : 1'b1;
  assign w_qual       = in_valid && ((mode_q != TRIG_WINDOW) || in_window);
  assign w_cap_active = ((state_q == S_WAIT_TRIG) && w_trig) || (state_q == S_CAPTURE);
  assign w_take       = w_cap_active && w_qual;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wcount_d  = wcount_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ser_load  = 1'b0;

    if (w_take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wcount_q;
      wr_data_d = in_data;
      wcount_d  = wcount_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          mode_d   = trig_mode;
          wcount_d = '0;
          state_d  = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: if (w_trig) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_CAPTURE;
      S_FETCH:     state_d = S_LATCH;
      S_LATCH: begin
        ser_load = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (ser_last) begin
          if (&rd_addr_q) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
`ifdef AUTO_REARM_EN
        state_d = S_WAIT_TRIG;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // The final address ends the window; wcount wraps back to zero here.
    if (w_take && (&wcount_q)) begin
      state_d   = S_FETCH;
      rd_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= TRIG_IMM;
      vsync_q   <= 1'b0;
      wcount_q  <= '0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      vsync_q   <= vsync;
      wcount_q  <= wcount_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .PAD_BYTES (PAD_BYTES)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .word     (ram_rd_data),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_strobe(tx_strobe),
    .last_byte(ser_last)
  );

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_dump_sequencer.sv
// ============================================================================
// Module : tb_capture_dump_sequencer
// Brief  : Directed bench for capture_dump_sequencer with a 1-cycle RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_capture_dump_sequencer;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int PB = 2;
`ifdef AUTO_REARM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic [1:0]    trig_mode = 2'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_window = 1'b0;
  logic          vsync = 1'b0;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [7:0]    tx_data;
  logic          tx_strobe;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  capture_dump_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAD_BYTES(PB)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode),
    .in_valid(in_valid), .in_data(in_data), .in_window(in_window), .vsync(vsync),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
    .busy(busy), .done(done), .state(state)
  );

  initial forever #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  logic [AW-1:0] wa_log[$];
  logic [DW-1:0] wd_log[$];
  logic [7:0]    tx_log[$];
  int            done_cnt = 0;
  int            consec   = 0;
  logic          prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (ram_wr_en) begin
      wa_log.push_back(ram_wr_addr);
      wd_log.push_back(ram_wr_data);
    end
    if (tx_strobe) begin
      tx_log.push_back(tx_data);
      if (prev_strobe) consec++;
    end
    prev_strobe = tx_strobe;
    if (done) done_cnt++;
  end

  int checks = 0;
  int errors = 0;
  bit data_inc = 1'b0;
  bit win_en = 1'b0;
  int phase = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (data_inc) in_data = in_data + 1;
    if (win_en) begin
      phase = (phase + 1) % 3;
      in_window = (phase == 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; arm = 1'b0; in_valid = 1'b0; in_window = 1'b0; vsync = 1'b0;
    tx_ready = 1'b1; data_inc = 1'b0; win_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    wa_log.delete(); wd_log.delete(); tx_log.delete();
    done_cnt = 0; consec = 0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 1000 && done_cnt < target; i++) tick();
    check({tag, "_done"}, done_cnt, target);
  endtask

  task automatic check_dump(input string tag, input logic [DW-1:0] base, input int step);
    logic [DW-1:0] w;
    logic [7:0]    eb;
    int            k;
    check({tag, "_nwr"}, wa_log.size(), 8);
    check({tag, "_nbytes"}, tx_log.size(), 48);
    for (int i = 0; i < 8; i++) begin
      w = base + DW'(step * i);
      if (i < wa_log.size()) begin
        check($sformatf("%s_waddr%0d", tag, i), wa_log[i], i);
        check($sformatf("%s_wdata%0d", tag, i), wd_log[i], w);
      end
      for (int j = 0; j < 6; j++) begin
        k  = 6 * i + j;
        eb = (j < 4) ? w[31 - 8 * j -: 8] : 8'h00;
        if (k < tx_log.size()) check($sformatf("%s_byte%0d", tag, k), tx_log[k], eb);
      end
    end
    check({tag, "_consec"}, consec, 0);
  endtask

  task automatic arm_mode(input logic [1:0] m);
    trig_mode = m; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_state", state, 3'd0);
    check("rst_outs", {ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, tx_data, tx_strobe, busy, done}, 0);

    // 1: immediate trigger, continuous samples
    in_valid = 1'b1;
    arm_mode(2'd0);
    check("t1_wait_state", state, 3'd1);
    in_data = 32'h11223344; data_inc = 1'b1;
    wait_done("t1", 1);
    tick();
    check_dump("t1", 32'h11223344, 1);
    check("t1_busy", busy, AUTO);

    // 2: vsync trigger; trig_mode change after arm must be ignored
    do_reset();
    in_valid = 1'b1; data_inc = 1'b1;
    arm_mode(2'd1);
    trig_mode = 2'd0;
    for (int i = 0; i < 20; i++) tick();
    check("t2_prerise_wr", wa_log.size(), 0);
    check("t2_prerise_state", state, 3'd1);
    vsync = 1'b1; in_data = 32'hA0000000;
    wait_done("t2", 1);
    check_dump("t2", 32'hA0000000, 1);

    // 3: vsync then window-only samples, window 1 on / 2 off
    do_reset();
    in_valid = 1'b1; in_window = 1'b1; data_inc = 1'b1;
    arm_mode(2'd2);
    for (int i = 0; i < 5; i++) tick();
    check("t3_prerise_wr", wa_log.size(), 0);
    vsync = 1'b1; in_data = 32'hB0000000; in_window = 1'b1; phase = 0; win_en = 1'b1;
    wait_done("t3", 1);
    win_en = 1'b0;
    check_dump("t3", 32'hB0000000, 3);

    // 4: tx_ready stall after byte 3
    do_reset();
    in_valid = 1'b1;
    arm_mode(2'd0);
    in_data = 32'h11223344; data_inc = 1'b1;
    for (int i = 0; i < 200 && tx_log.size() < 3; i++) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("t4_stall_bytes", tx_log.size(), 3);
    check("t4_stall_state", state, 3'd5);
    tx_ready = 1'b1;
    wait_done("t4", 1);
    check_dump("t4", 32'h11223344, 1);

    // 5: reset during SEND, then a clean capture
    do_reset();
    in_valid = 1'b1;
    arm_mode(2'd0);
    in_data = 32'h11223344; data_inc = 1'b1;
    for (int i = 0; i < 200 && tx_log.size() < 2; i++) tick();
    check("t5_in_send", state, 3'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_rst_state", state, 3'd0);
    check("t5_rst_outs", {ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, tx_data, tx_strobe, busy, done}, 0);
    begin
      int nb;
      nb = tx_log.size();
      for (int i = 0; i < 30; i++) tick();
      check("t5_abandoned", tx_log.size(), nb);
      check("t5_no_done", done_cnt, 0);
    end
    wa_log.delete(); wd_log.delete(); tx_log.delete(); consec = 0;
    arm_mode(2'd0);
    in_data = 32'h55667788;
    wait_done("t5", 1);
    check_dump("t5", 32'h55667788, 1);

    // 6: arm during CAPTURE is ignored
    do_reset();
    in_valid = 1'b0;
    arm_mode(2'd0);
    tick(); tick(); tick();
    check("t6_capture_state", state, 3'd2);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    in_valid = 1'b1; in_data = 32'hD0000000; data_inc = 1'b1;
    wait_done("t6", 1);
    check_dump("t6", 32'hD0000000, 1);
    for (int i = 0; i < 400 && done_cnt < 2; i++) tick();
    check("t6_done_total", done_cnt, AUTO ? 2 : 1);
    check("t6_busy_end", busy, AUTO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/capture_dump_sequencer.md
Name: capture_dump_sequencer

Overview:
Controls the TMDS debug capture RAM and the UART dump path. It arms on request, waits for a selectable trigger, and fills the RAM with one capture window of sample words. It then reads the RAM back and serialises each word MSB-first into UART byte strobes, with zero pad bytes after each word. It sits between the decoded-TMDS sample source, the dual-port ram instance and the uart transmitter, replacing ad-hoc wr_addr/rd_addr logic in top.

Parameters:
DATA_WIDTH, 32, sample word width; must be a multiple of 8
ADDR_WIDTH, 11, RAM address width; capture depth = 2**ADDR_WIDTH words
PAD_BYTES, 2, zero bytes sent after each word (0..3)

Ports:
clk  in  1  capture/dump clock; all ports synchronous to it
reset  in  1  synchronous, active-low reset
arm  in  1  single-cycle request to start a capture; ignored unless busy=0
trig_mode  in  2  0=immediate, 1=vsync rising edge, 2=vsync rising edge then only window samples, 3=reserved (treated as 0)
in_valid  in  1  sample qualifier
in_data  in  DATA_WIDTH  sample word
in_window  in  1  sample lies inside the active capture window
vsync  in  1  frame sync from the hdmi stream
ram_wr_en  out  1  RAM write enable
ram_wr_addr  out  ADDR_WIDTH  RAM write address
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_rd_addr
tx_data  out  8  UART byte
tx_strobe  out  1  one-cycle byte-valid pulse
tx_ready  in  1  UART can accept a byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the dump completes
state  out  3  current state encoding, for LEDs and debug

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE. All outputs are 0. Internal addresses, shift register and byte counter clear. Applies mid-capture or mid-dump; the dump is abandoned.
- State encoding: IDLE=0, WAIT_TRIG=1, CAPTURE=2, FETCH=3, LATCH=4, SEND=5, DONE=6.
- IDLE: arm=1 -> WAIT_TRIG. Registers trig_mode at this point; later changes to trig_mode are ignored until the next arm.
- Edge detect: vsync_d is registered every cycle. rise = vsync && !vsync_d.
- WAIT_TRIG to CAPTURE:
  - mode 0: next cycle.
  - modes 1 and 2: the cycle that rise=1.
  - The trigger-cycle sample is captured if it qualifies.
- Qualifying sample: in_valid=1, and additionally in_window=1 in mode 2.
- Write path (active in the trigger cycle and in CAPTURE):
  - each qualifying sample asserts ram_wr_en=1 for 1 cycle, with ram_wr_data=in_data and ram_wr_addr=wcount; wcount then increments.
  - registered outputs: the write appears 1 cycle after the sample.
- CAPTURE exit: after the write of address 2**ADDR_WIDTH-1, go to FETCH with ram_rd_addr=0. No wrap and no further writes after that point.
- FETCH: 1 cycle, waiting out RAM latency -> LATCH.
- LATCH: shift register <= ram_rd_data; bytes_left <= DATA_WIDTH/8+PAD_BYTES -> SEND.
- SEND:
  - when tx_ready=1 and tx_strobe=0: tx_strobe=1, tx_data=shreg[MSB byte], shreg shifts left by 8 with zero fill, bytes_left decrements.
  - never strobe on two consecutive cycles.
  - when bytes_left reaches 0: if ram_rd_addr=all-ones -> DONE; otherwise increment ram_rd_addr -> FETCH.
- DONE: done=1 for one cycle -> IDLE.
- arm while busy=1 is ignored and is not queued.
- tx_ready deasserting mid-word stalls SEND indefinitely. No timeout.
- Byte count per dump: 2**ADDR_WIDTH*(DATA_WIDTH/8+PAD_BYTES).

Optional Feature:
AUTO_REARM_EN:
- Defined: DONE moves to WAIT_TRIG with the latched trig_mode kept, instead of to IDLE. busy stays 1. The block captures and dumps continuously. arm is ignored after the first capture. Only reset returns the block to IDLE.
- Undefined: single-shot behaviour as described above.

Decomposition:
- Shared package capture_pkg:
  - state encoding localparams (ST_IDLE..ST_DONE)
  - trig_mode constants (TRIG_IMM, TRIG_VSYNC, TRIG_WINDOW)
  - function bytes_per_word(DATA_WIDTH, PAD_BYTES)
- One sub-module, word_serializer: shift register, byte counter and the tx_ready/tx_strobe handshake. Ports: load, word, tx_*, last_byte.
- Sequencer FSM and address counters stay in capture_dump_sequencer.

Test Plan:
(Bench uses ADDR_WIDTH=3, DATA_WIDTH=32, PAD_BYTES=2, and a behavioural 1-cycle-latency RAM.)
1. Mode 0, arm, in_valid=1 continuously, in_data=0x11223344+n -> 8 writes to addresses 0..7. Then 48 tx_strobe pulses, word 0 sent as 44 33 22 11? No: MSB-first, so 11 22 33 44 00 00. done pulses once; busy=0 afterwards.
2. Mode 1, vsync held low for 20 cycles then raised -> no ram_wr_en before the rise; the first write (address 0) carries the sample from the rise cycle.
3. Mode 2, in_window toggling 1 cycle on / 2 cycles off -> only window samples are written; addresses are contiguous 0..7.
4. tx_ready low for 50 cycles mid-word, after byte 3 -> no strobes while low; byte 4 resumes correctly; total strobe count is still 48.
5. reset=0 for 1 cycle during SEND -> next cycle state=0 and all outputs 0. A new arm produces a full, clean capture.
6. arm pulsed during CAPTURE -> ignored; exactly one dump and one done pulse. With AUTO_REARM_EN: a second capture follows with no second arm.
